// File: rtl/arch_defs_pkg.sv
// Shared architectural definitions for the memory-mapped peripherals.
// Holds the UART transmitter address map, status bit layout and FSM states.
package arch_defs_pkg;

    localparam logic [15:0] UART_BASE_ADDR     = 16'hE000;
    localparam int          UART_DATA_OFFSET   = 0;
    localparam int          UART_STATUS_OFFSET = 1;

    localparam int UART_ST_BUSY  = 0;
    localparam int UART_ST_FULL  = 1;
    localparam int UART_ST_EMPTY = 2;
    localparam int UART_ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serialiser: start bit, eight data bits LSB first, one stop bit.
// Accepts a byte when ready_o is high: while idle, or in the last stop cycle.
module uart_tx_serializer
    import arch_defs_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           baud_done;

    assign baud_done = (baud_q == BAUD_LAST);
    assign ready_o   = (state_q == IDLE) | ((state_q == STOP) & baud_done);
    assign tx_o      = tx_q;
    assign busy_o    = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (valid_i) begin
                    shift_d = data_i;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Back-to-back frames: next start bit follows with no idle gap
                    if (valid_i) begin
                        shift_d = data_i;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA/STATUS register decode and TX FIFO
// in front of the 8N1 serialiser.
module uart_tx_mmio
    import arch_defs_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = UART_BASE_ADDR,
    parameter int                    CLKS_PER_BIT = 16,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  sel,
    output logic                  uart_tx,
    output logic                  tx_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DATA_ADDR =
        BASE_ADDR + ADDR_WIDTH'(UART_DATA_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] STAT_ADDR =
        BASE_ADDR + ADDR_WIDTH'(UART_STATUS_OFFSET);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic data_hit, stat_hit;
    logic push_req, push, pop, ovf_set, stat_rd;
    logic fifo_empty, fifo_full;
    logic ser_ready, ser_busy;

    assign data_hit   = (mem_address == DATA_ADDR);
    assign stat_hit   = (mem_address == STAT_ADDR);
    assign sel        = data_hit | stat_hit;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = ser_ready & ~fifo_empty;
    assign push_req   = mem_write & data_hit;
    // A full FIFO still accepts a byte when a slot frees on the same edge
    assign push       = push_req & (~fifo_full | pop);
    assign ovf_set    = push_req & ~push;
    assign stat_rd    = mem_read & stat_hit;
    assign tx_busy    = ser_busy | ~fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push & ~pop) count_d = count_q + CW'(1);
        if (pop & ~push) count_d = count_q - CW'(1);
        // Set wins over the read-to-clear
        ovf_d = ovf_set | (ovf_q & ~stat_rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) mem_q[wr_ptr_q] <= bus_data_in[7:0];
        end
    end

    always_comb begin
        bus_data_out = '0;
        if (stat_rd) begin
            bus_data_out[UART_ST_BUSY]  = tx_busy;
            bus_data_out[UART_ST_FULL]  = fifo_full;
            bus_data_out[UART_ST_EMPTY] = fifo_empty;
            bus_data_out[UART_ST_OVF]   = ovf_q;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk    (clk),
        .reset  (reset),
        .valid_i(~fifo_empty),
        .data_i (mem_q[rd_ptr_q]),
        .ready_o(ser_ready),
        .tx_o   (uart_tx),
        .busy_o (ser_busy)
    );

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: line-level model of frames,
// FIFO occupancy and sticky overflow, checked every cycle.
module tb_uart_tx_mmio;

    localparam int CPB = 4;
    localparam int FL  = 10 * CPB;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        sel;
    logic        uart_tx;
    logic        tx_busy;

    uart_tx_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .bus_data_in (bus_data_in),
        .bus_data_out(bus_data_out),
        .sel         (sel),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;

    // Model: every accepted byte and the edge at which its frame starts
    logic [7:0] acc_q[$];
    int         st_q[$];
    bit         ovf_m = 1'b0;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic exp_tx(int c);
        for (int i = 0; i < st_q.size(); i++) begin
            if (c >= st_q[i] && c < st_q[i] + FL) begin
                int idx = (c - st_q[i]) / CPB;
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return acc_q[i][idx-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic int pending(int c);
        int n = 0;
        foreach (st_q[i]) if (st_q[i] > c) n++;
        return n;
    endfunction

    function automatic logic exp_busy(int c);
        foreach (st_q[i]) if (c >= st_q[i] && c < st_q[i] + FL) return 1'b1;
        return pending(c) != 0;
    endfunction

    function automatic logic [7:0] exp_status(int c);
        int p = pending(c);
        return {4'b0, ovf_m, 1'(p == 0), 1'(p == DEP), exp_busy(c)};
    endfunction

    function automatic int last_end();
        return (st_q.size() != 0) ? st_q[st_q.size()-1] + FL : 0;
    endfunction

    task automatic model_clear();
        acc_q.delete();
        st_q.delete();
        ovf_m = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        chk("uart_tx", 8'(uart_tx), 8'(exp_tx(cyc)));
        chk("tx_busy", 8'(tx_busy), 8'(exp_busy(cyc)));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(logic [15:0] a, logic [7:0] d);
        int t = cyc + 1;
        mem_address = a;
        bus_data_in = d;
        mem_write   = 1'b1;
        #1;
        chk("sel_wr", 8'(sel), 8'(a == 16'hE000 || a == 16'hE001));
        if (a == 16'hE000) begin
            int infifo = 0;
            int popnow = 0;
            foreach (st_q[i]) begin
                if (st_q[i] >= t) infifo++;
                if (st_q[i] == t) popnow = 1;
            end
            if (infifo - popnow < DEP) begin
                int s = t + 1;
                if (last_end() > s) s = last_end();
                acc_q.push_back(d);
                st_q.push_back(s);
            end else begin
                ovf_m = 1'b1;
            end
        end
        tick();
        mem_write = 1'b0;
    endtask

    task automatic st_rd();
        mem_address = 16'hE001;
        mem_read    = 1'b1;
        #1;
        chk("sel_st", 8'(sel), 8'h01);
        chk("status", bus_data_out, exp_status(cyc));
        tick();
        mem_read = 1'b0;
        ovf_m    = 1'b0;
    endtask

    task automatic drain();
        int lim = last_end() + 2;
        while (cyc < lim) tick();
    endtask

    task automatic reset_now();
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_tx", 8'(uart_tx), 8'h01);
        chk("rst_busy", 8'(tx_busy), 8'h00);
        mem_address = 16'hE001;
        mem_read    = 1'b1;
        #1;
        chk("rst_status", bus_data_out, 8'h04);
        mem_read = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        int k;
        int s0;
        logic [15:0] addrs [4];
        addrs[0] = 16'hE000;
        addrs[1] = 16'hE001;
        addrs[2] = 16'hE002;
        addrs[3] = 16'hDFFF;

        reset       = 1'b1;
        mem_address = 16'h0000;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        bus_data_in = 8'h00;
        #2;
        chk("por_tx", 8'(uart_tx), 8'h01);
        chk("por_busy", 8'(tx_busy), 8'h00);
        mem_address = 16'hE001;
        mem_read    = 1'b1;
        #1;
        chk("por_status", bus_data_out, 8'h04);
        mem_read = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(2);

        // Single byte A5: exact waveform checked cycle by cycle
        wr(16'hE000, 8'hA5);
        drain();
        chk("a5_idle_status", 8'(tx_busy), 8'h00);

        // Burst 01..05, full status, then overflow on 06
        k = cyc + 1;
        for (int i = 1; i <= 5; i++) wr(16'hE000, 8'(i));
        st_rd();
        wr(16'hE000, 8'h06);
        st_rd();
        st_rd();
        while (cyc < k + 40) tick();
        wr(16'hE000, 8'h07);
        mem_address = 16'hE001;
        mem_read    = 1'b1;
        #1;
        chk("full_push_pop", bus_data_out, 8'h03);
        mem_read = 1'b0;
        st_rd();
        drain();

        // Decode: out-of-window and register reads
        wr(16'hE002, 8'h55);
        wr(16'hDFFF, 8'hAA);
        wr(16'hE001, 8'h77);
        mem_address = 16'hE000;
        mem_read    = 1'b1;
        #1;
        chk("data_read", bus_data_out, 8'h00);
        chk("data_sel", 8'(sel), 8'h01);
        mem_address = 16'hE001;
        mem_read    = 1'b0;
        #1;
        chk("status_noread", bus_data_out, 8'h00);
        mem_address = 16'hE002;
        mem_read    = 1'b1;
        #1;
        chk("outside_read", bus_data_out, 8'h00);
        mem_read = 1'b0;
        st_rd();
        idle(3);

        // Randomized bursts with gaps, stray accesses and status polls
        for (int b = 0; b < 8; b++) begin
            int n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0)
                    wr(addrs[$urandom_range(1, 3)], 8'($urandom));
                else
                    wr(16'hE000, 8'($urandom));
                idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 1) == 1) st_rd();
            idle($urandom_range(0, 120));
        end
        drain();
        st_rd();

        // Reset during data bit 3 with two bytes queued
        s0 = cyc + 2;
        wr(16'hE000, 8'($urandom) & 8'hF7);
        wr(16'hE000, 8'($urandom));
        wr(16'hE000, 8'($urandom));
        while (cyc < s0 + 4 * CPB + 1) tick();
        chk("pre_rst_tx", 8'(uart_tx), 8'h00);
        reset_now();
        idle(2);
        st_rd();
        wr(16'hE000, 8'h3C);
        drain();
        st_rd();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU memory bus, alongside RAM. It decodes CPU bus strobes in a small address window and buffers written bytes in a 4-entry FIFO. Bytes are serialised 8N1 on a single TX pin, and a status register is exposed for CPU polling. The top-level read mux uses `sel` to route this block's read data onto the CPU's mem_data_in.

Parameters:
BASE_ADDR, 16'hE000, address of the DATA register; STATUS is at BASE_ADDR+1.
CLKS_PER_BIT, 16, clock cycles per serial bit (≥2).
FIFO_DEPTH, 4, TX FIFO entries (power of 2).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
mem_address  input  ADDR_WIDTH  CPU-driven address
mem_read  input  1  CPU read strobe
mem_write  input  1  CPU write strobe
bus_data_in  input  DATA_WIDTH  write data from the CPU
bus_data_out  output  DATA_WIDTH  read data to the top-level read mux
sel  output  1  high when mem_address is inside the window (BASE_ADDR..BASE_ADDR+1)
uart_tx  output  1  serial output, idle high
tx_busy  output  1  high while the serialiser is not IDLE or the FIFO is non-empty

Behaviour:
- One clock; reset is asynchronous and active-high. It forces FIFO empty, pointers 0, overflow=0, serialiser IDLE, uart_tx=1, tx_busy=0.
- Decode (combinational):
  - sel = (mem_address==BASE_ADDR) | (mem_address==BASE_ADDR+1).
  - Accesses outside the window are ignored.
  - bus_data_out is 8'h00 when mem_read=0 or sel=0.
- DATA write (mem_write & address==BASE_ADDR):
  - Push bus_data_in at the clock edge if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise drop the byte and set sticky overflow=1.
- DATA read returns 8'h00.
- STATUS read (combinational, same cycle as mem_read): {4'b0, overflow, fifo_empty, fifo_full, tx_busy} = bits [3]..[0].
  - On the edge ending a cycle with a STATUS read, overflow clears to 0.
  - If an overflow event coincides with that edge, overflow stays 1 (set wins).
- STATUS write is ignored.
- FIFO:
  - count range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push+pop leaves count unchanged.
  - fifo_full = (count==FIFO_DEPTH); fifo_empty = (count==0).
- Serialiser FSM states: IDLE, START, DATA, STOP. bit_cnt is 0..7; baud_cnt is 0..CLKS_PER_BIT-1.
  - IDLE:
    - uart_tx=1.
    - If FIFO is non-empty: pop into shift reg, uart_tx<=0, baud_cnt<=0, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with uart_tx<=shift[0].
  - DATA:
    - Each bit lasts CLKS_PER_BIT cycles, sent LSB first.
    - After bit 7, go to STOP with uart_tx<=1.
  - STOP: hold 1 for CLKS_PER_BIT cycles, then:
    - If FIFO is non-empty: pop and go directly to START (back-to-back, no idle gap).
    - Else go to IDLE.
- Latency:
  - A write captured at edge k into an empty FIFO with the serialiser IDLE pops at edge k+1.
  - uart_tx falls at edge k+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Registered outputs: uart_tx is registered, so there are no glitches.
- Mid-frame reset: uart_tx returns to 1 immediately (asynchronously) and queued bytes are discarded.
- Simultaneous mem_read and mem_write: both are honoured independently.

Decomposition:
- Add to arch_defs_pkg:
  - UART_BASE_ADDR.
  - UART_DATA_OFFSET=0 and UART_STATUS_OFFSET=1.
  - Status bit indices UART_ST_BUSY=0, UART_ST_FULL=1, UART_ST_EMPTY=2, UART_ST_OVF=3.
  - typedef enum uart_tx_state_t {IDLE, START, DATA, STOP}.
- One sub-module: uart_tx_serializer, holding the FSM, baud counter, bit counter and shift register.
  - Interface: valid/ready; ready=1 in IDLE and on the last STOP cycle.
  - The FIFO and register decode stay in uart_tx_mmio.

Test Plan:
- Reset test: assert reset mid-cycle -> uart_tx=1, tx_busy=0, and a STATUS read returns 8'h04, with no clock needed for the reset values.
- Single byte, CLKS_PER_BIT=4: write 8'hA5 to 16'hE000.
  - uart_tx falls at the next edge and holds 0 for 4 cycles.
  - Data bits follow as 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop bit is 1 for 4 cycles; tx_busy drops after exactly 40 cycles of frame.
- Overflow, serialiser idle: write 8'h01..8'h06 on 6 consecutive cycles.
  - Bytes 01-05 are transmitted in order, back-to-back with no gap between stop and start.
  - Byte 06 is never sent.
  - STATUS read reports overflow=1 (bit3); a second STATUS read reports overflow=0.
- Full FIFO status: after the first 5 writes -> STATUS bit1 (full)=1 and bit0=1.
  - Write and pop on the same edge while full -> byte accepted, no overflow.
- Decode: write to 16'hE002 and 16'hDFFF -> no FIFO change and sel=0.
  - Read DATA -> 8'h00.
  - Read STATUS while mem_read=0 -> bus_data_out=8'h00.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> uart_tx=1 immediately and the FIFO is empty.
  - After release, a new write of 8'h3C transmits correctly.
